button_event_ctrl: RTL

//  Turns N raw active-low push-buttons into a stream of timed key events: PRESS, RELEASE, LONG and REPEAT.

---
 rtl/button_event_ctrl_pkg.sv | 23 ++
 rtl/button_event_ctrl_if.sv | 17 +
 rtl/button_event_ctrl_timer_fsm.sv | 91 +++++++++
 rtl/button_event_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared types for the button event controller: per-button FSM states and event codes.
package button_event_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DB_PRS = 3'd1,
        ST_HELD   = 3'd2,
        ST_RPT    = 3'd3,
        ST_DB_REL = 3'd4
    } btn_state_t;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;

    function automatic int btn_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready key-event port: producer drives valid/btn/code, consumer drives ready.
interface button_event_ctrl_if #(
    parameter int N_BTN = 4
);
    import button_event_ctrl_pkg::*;

    localparam int BTN_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic             valid;
    logic             ready;
    logic [BTN_W-1:0] btn;
    evt_code_t        code;

    modport master (output valid, btn, code, input ready);
    modport slave  (input valid, btn, code, output ready);

endinterface

// File: rtl/button_event_ctrl_timer_fsm.sv
// One button: 2-FF synchroniser, debounce/long/repeat timer FSM, single-cycle event raise.
module btn_timer_fsm
    import button_event_ctrl_pkg::*;
#(
    parameter int             CNT_W    = 20,
    parameter logic [CNT_W-1:0] DB_CYC   = 20'd500000,
    parameter logic [CNT_W-1:0] LONG_CYC = 20'd1000000,
    parameter logic [CNT_W-1:0] REP_CYC  = 20'd250000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      btn_n,
    output logic      raise,
    output evt_code_t code,
    output logic      held
);

    logic [1:0]       sync_q;
    logic             s;
    btn_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    assign s = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            state  <= ST_IDLE;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], ~btn_n};
            state  <= state_d;
            cnt    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        raise   = 1'b0;
        code    = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (s) state_d = ST_DB_PRS;
            end
            ST_DB_PRS: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (cnt == DB_CYC - 1'b1) begin
                    state_d = ST_HELD;
                    raise   = 1'b1;
                    code    = EVT_PRESS;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_DB_REL;
                end else if (cnt == LONG_CYC - 1'b1) begin
                    state_d = ST_RPT;
                    raise   = 1'b1;
                    code    = EVT_LONG;
                end
            end
            ST_RPT: begin
                if (!s) begin
                    state_d = ST_DB_REL;
                end else if (cnt == REP_CYC - 1'b1) begin
                    raise = 1'b1;
                    code  = EVT_REPEAT;
                    cnt_d = '0;
                end
            end
            ST_DB_REL: begin
                // A bounce back to pressed returns to HELD silently and restarts the long timer
                if (s) begin
                    state_d = ST_HELD;
                end else if (cnt == DB_CYC - 1'b1) begin
                    state_d = ST_IDLE;
                    raise   = 1'b1;
                    code    = EVT_RELEASE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state) cnt_d = '0;
    end

    assign held = (state == ST_HELD) || (state == ST_RPT) || (state == ST_DB_REL);

endmodule

// File: rtl/button_event_ctrl.sv
// N debounced buttons -> one-deep pending slot per button -> round-robin -> registered valid/ready port.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int               N_BTN    = 4,
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] DB_CYC   = 20'd500000,
    parameter logic [CNT_W-1:0] LONG_CYC = 20'd1000000,
    parameter logic [CNT_W-1:0] REP_CYC  = 20'd250000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_BTN-1:0]         btn_n_i,
    button_event_ctrl_if.master      evt,
    output logic [N_BTN-1:0]         held_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i
);

    localparam int               BTN_W = btn_w(N_BTN);
    localparam logic [BTN_W:0]   NB    = (BTN_W + 1)'(N_BTN);

    logic [N_BTN-1:0] raise, pend, gnt_vec;
    evt_code_t        rcode [N_BTN];
    evt_code_t        pcode [N_BTN];

    logic             vld_q;
    logic [BTN_W-1:0] btn_q, rr, gnt_idx;
    evt_code_t        code_q;
    logic [BTN_W:0]   idx;
    logic             gnt_any, load, ovf_set;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_timer_fsm #(
            .CNT_W   (CNT_W),
            .DB_CYC  (DB_CYC),
            .LONG_CYC(LONG_CYC),
            .REP_CYC (REP_CYC)
        ) u_fsm (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .btn_n (btn_n_i[i]),
            .raise (raise[i]),
            .code  (rcode[i]),
            .held  (held_o[i])
        );
    end

    // First pending button after rr, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = {1'b0, rr} + (BTN_W + 1)'(k);
            if (idx >= NB) idx = idx - NB;
            if (!gnt_any && pend[idx[BTN_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[BTN_W-1:0];
            end
        end
    end

    assign load    = !vld_q || evt.ready;
    assign gnt_vec = (load && gnt_any) ? (N_BTN'(1) << gnt_idx) : '0;
    // A new raise on a slot that is moving out this cycle is not an overwrite
    assign ovf_set = |(raise & pend & ~gnt_vec);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
            for (int i = 0; i < N_BTN; i++) pcode[i] <= EVT_PRESS;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (raise[i]) begin
                    pend[i]  <= 1'b1;
                    pcode[i] <= rcode[i];
                end else if (gnt_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            btn_q  <= '0;
            code_q <= EVT_PRESS;
            rr     <= '0;
        end else if (load) begin
            vld_q <= gnt_any;
            if (gnt_any) begin
                btn_q  <= gnt_idx;
                code_q <= pcode[gnt_idx];
                rr     <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          ovf_o <= 1'b0;
        else if (ovf_set)   ovf_o <= 1'b1;
        else if (ovf_clr_i) ovf_o <= 1'b0;
    end

    assign evt.valid = vld_q;
    assign evt.btn   = btn_q;
    assign evt.code  = code_q;

endmodule
